// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, sprite field widths and slice helpers
package vga_pkg;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_ACT_START = 144;
  localparam int VGA_H_ACT_END   = 784;
  localparam int VGA_V_TOTAL     = 521;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_ACT_START = 31;
  localparam int VGA_V_ACT_END   = 511;

  localparam int COORD_W = 10;
  localparam int FOFF_W  = 9;
  localparam int POS_W   = 2 * COORD_W;
  localparam int OFF_W   = 2 * FOFF_W;
  localparam int RGB_W   = 8;
  localparam int ADDR_W  = 16;

  localparam logic [RGB_W-1:0] KEY_DEFAULT = 8'hFF;

  // spr_pos packs {x, y}; spr_off packs {hoff, voff}
  function automatic logic [COORD_W-1:0] pos_x(input logic [POS_W-1:0] pos);
    return pos[POS_W-1 -: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] pos_y(input logic [POS_W-1:0] pos);
    return pos[COORD_W-1:0];
  endfunction

  function automatic logic [FOFF_W-1:0] off_h(input logic [OFF_W-1:0] off);
    return off[OFF_W-1 -: FOFF_W];
  endfunction

  function automatic logic [FOFF_W-1:0] off_v(input logic [OFF_W-1:0] off);
    return off[FOFF_W-1:0];
  endfunction

endpackage

// File: rtl/vga_sprite_compositor_if.sv
// rtl/vga_sprite_compositor_if.sv - sprite ROM, position and VGA pin bundle of the compositor
interface vga_sprite_compositor_if
  import vga_pkg::*;
#(
  parameter int N_SPR = 2
);

  logic [N_SPR*POS_W-1:0]  spr_pos;
  logic [N_SPR*OFF_W-1:0]  spr_off;
  logic [N_SPR*ADDR_W-1:0] spr_addr;
  logic [N_SPR*RGB_W-1:0]  spr_data;
  logic [RGB_W-1:0]        bg_rgb;
  logic [COORD_W-1:0]      hcount;
  logic [COORD_W-1:0]      vcount;
  logic                    pix_en;
  logic [2:0]              r;
  logic [2:0]              g;
  logic [1:0]              b;
  logic                    hs;
  logic                    vs;
  logic [N_SPR-1:0]        coll_frame;

  modport master (
    input  spr_pos, spr_off, spr_data, bg_rgb,
    output spr_addr, hcount, vcount, pix_en, r, g, b, hs, vs, coll_frame
  );

  modport slave (
    output spr_pos, spr_off, spr_data, bg_rgb,
    input  spr_addr, hcount, vcount, pix_en, r, g, b, hs, vs, coll_frame
  );

endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel divider, h/v counters, raw syncs, active window and frame-start tick
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_ACT_END   = VGA_H_ACT_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_ACT_END   = VGA_V_ACT_END
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] hcount,
  output logic [COORD_W-1:0] vcount,
  output logic               hs_raw,
  output logic               vs_raw,
  output logic               active,
  output logic               frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_SYNC_C = COORD_W'(H_SYNC);
  localparam logic [COORD_W-1:0] V_SYNC_C = COORD_W'(V_SYNC);
  localparam logic [COORD_W-1:0] H_AS = COORD_W'(H_ACT_START);
  localparam logic [COORD_W-1:0] H_AE = COORD_W'(H_ACT_END);
  localparam logic [COORD_W-1:0] V_AS = COORD_W'(V_ACT_START);
  localparam logic [COORD_W-1:0] V_AE = COORD_W'(V_ACT_END);

  logic [DIV_W-1:0] div;

  // CLK_DIV is a power of two, so the divider wraps on its own
  assign pix_en      = (div == DIV_W'(CLK_DIV - 1));
  assign frame_start = pix_en && (hcount == '0) && (vcount == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      div <= div + 1'b1;
      if (pix_en) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end
    end
  end

  assign hs_raw = (hcount >= H_SYNC_C);
  assign vs_raw = (vcount >= V_SYNC_C);
  assign active = (hcount >= H_AS) && (hcount < H_AE) &&
                  (vcount >= V_AS) && (vcount < V_AE);

endmodule

// File: rtl/vga_sprite_compositor.sv
// rtl/vga_sprite_compositor.sv - VGA timing plus N-sprite colour-key compositor; VGA_SPR_COLLIDE_EN builds collision capture
module vga_sprite_compositor
  import vga_pkg::*;
#(
  parameter int N_SPR       = 2,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int SHEET_W     = 48,
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_ACT_END   = VGA_H_ACT_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_ACT_END   = VGA_V_ACT_END,
  parameter logic [RGB_W-1:0] KEY = KEY_DEFAULT
) (
  input logic                     clk,
  input logic                     rst,
  vga_sprite_compositor_if.master bus
);

  localparam logic [COORD_W-1:0] SPR_W_C   = COORD_W'(SPR_W);
  localparam logic [COORD_W-1:0] SPR_H_C   = COORD_W'(SPR_H);
  localparam logic [ADDR_W-1:0]  SHEET_W_C = ADDR_W'(SHEET_W);

  logic               pix_en;
  logic [COORD_W-1:0] hcount;
  logic [COORD_W-1:0] vcount;
  logic               hs_raw;
  logic               vs_raw;
  logic               active;
  logic               frame_start;

  vga_timing_gen #(
    .CLK_DIV    (CLK_DIV),
    .H_TOTAL    (H_TOTAL),
    .H_SYNC     (H_SYNC),
    .H_ACT_START(H_ACT_START),
    .H_ACT_END  (H_ACT_END),
    .V_TOTAL    (V_TOTAL),
    .V_SYNC     (V_SYNC),
    .V_ACT_START(V_ACT_START),
    .V_ACT_END  (V_ACT_END)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .active     (active),
    .frame_start(frame_start)
  );

  logic [N_SPR-1:0][POS_W-1:0]  sh_pos;
  logic [N_SPR-1:0][OFF_W-1:0]  sh_off;
  logic [N_SPR-1:0]             hit_c;
  logic [N_SPR-1:0][ADDR_W-1:0] addr_c;
  logic [N_SPR-1:0]             hit_a;
  logic [N_SPR-1:0][ADDR_W-1:0] addr_q;
  logic                         active_a;
  logic                         hs_a;
  logic                         vs_a;
  logic [N_SPR-1:0][RGB_W-1:0]  spr_dat;
  logic [N_SPR-1:0]             opaque;
  logic [RGB_W-1:0]             pix_sel;
  logic [RGB_W-1:0]             rgb_q;
  logic                         hs_q;
  logic                         vs_q;

  assign spr_dat = bus.spr_data;

  // The extra top bit of each difference is the borrow: a counter left of or
  // above the sprite origin is a negative offset and must never hit.
  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    logic [COORD_W:0]  hdiff;
    logic [COORD_W:0]  vdiff;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    assign hdiff = {1'b0, hcount} - {1'b0, pos_x(sh_pos[i])};
    assign vdiff = {1'b0, vcount} - {1'b0, pos_y(sh_pos[i])};

    assign hit_c[i] = !hdiff[COORD_W] && !vdiff[COORD_W] &&
                      (hdiff[COORD_W-1:0] < SPR_W_C) &&
                      (vdiff[COORD_W-1:0] < SPR_H_C);

    assign row       = ADDR_W'(vdiff[COORD_W-1:0]) + ADDR_W'(off_v(sh_off[i]));
    assign col       = ADDR_W'(hdiff[COORD_W-1:0]) + ADDR_W'(off_h(sh_off[i]));
    assign addr_c[i] = row * SHEET_W_C + col;

    assign opaque[i] = hit_a[i] && (spr_dat[i] != KEY);
  end

  // Fixed priority: scanning downwards leaves the lowest-index opaque sprite
  always_comb begin
    pix_sel = bus.bg_rgb;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) pix_sel = spr_dat[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_pos   <= '0;
      sh_off   <= '0;
      hit_a    <= '0;
      addr_q   <= '0;
      active_a <= 1'b0;
      hs_a     <= 1'b0;
      vs_a     <= 1'b0;
      rgb_q    <= '0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
    end else if (pix_en) begin
      if (frame_start) begin
        sh_pos <= bus.spr_pos;
        sh_off <= bus.spr_off;
      end
      hit_a    <= hit_c;
      addr_q   <= addr_c;
      active_a <= active;
      hs_a     <= hs_raw;
      vs_a     <= vs_raw;
      rgb_q    <= active_a ? pix_sel : '0;
      hs_q     <= hs_a;
      vs_q     <= vs_a;
    end
  end

`ifdef VGA_SPR_COLLIDE_EN
  logic [N_SPR-1:0] coll_acc;
  logic [N_SPR-1:0] coll_q;
  logic [N_SPR-1:0] coll_set;

  // Two or more bits set <=> clearing the lowest set bit leaves something
  assign coll_set = ((opaque & (opaque - N_SPR'(1))) != '0) ? opaque : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_acc <= '0;
      coll_q   <= '0;
    end else if (pix_en) begin
      if (frame_start) begin
        coll_q   <= coll_acc;
        coll_acc <= coll_set;
      end else begin
        coll_acc <= coll_acc | coll_set;
      end
    end
  end

  assign bus.coll_frame = coll_q;
`else
  assign bus.coll_frame = '0;
`endif

  assign bus.pix_en   = pix_en;
  assign bus.hcount   = hcount;
  assign bus.vcount   = vcount;
  assign bus.spr_addr = addr_q;
  assign bus.r        = rgb_q[7:5];
  assign bus.g        = rgb_q[4:2];
  assign bus.b        = rgb_q[1:0];
  assign bus.hs       = hs_q;
  assign bus.vs       = vs_q;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb/tb_vga_sprite_compositor.sv - directed bench on a shrunken 48x12 raster with a 1-clk sprite ROM model
module tb_vga_sprite_compositor;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  localparam logic [19:0] PARK = {10'd1000, 10'd1000};

  vga_sprite_compositor_if #(.N_SPR(2)) bus ();

  vga_sprite_compositor #(
    .N_SPR      (2),
    .CLK_DIV    (4),
    .H_TOTAL    (48),
    .H_SYNC     (4),
    .H_ACT_START(1),
    .H_ACT_END  (40),
    .V_TOTAL    (12),
    .V_SYNC     (2),
    .V_ACT_START(2),
    .V_ACT_END  (11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] force_en;
  logic [7:0] force_val [2];
  logic [7:0] rom_q [2];

  // Synchronous ROM: returns addr[7:0] unless a fixed colour is forced
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      rom_q[i] <= force_en[i] ? force_val[i] : bus.spr_addr[i*16 +: 8];
  end
  assign bus.spr_data = {rom_q[1], rom_q[0]};

  wire [7:0] rgb = {bus.r, bus.g, bus.b};

  task automatic wait_pix(input int h, input int v);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (bus.pix_en && bus.hcount == h && bus.vcount == v) break;
    end
    if (k == 5000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_pix(%0d,%0d): timeout, got h=%0d v=%0d", h, v, bus.hcount, bus.vcount);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.hcount !== 10'd0) begin n_fail++; $display("FAIL reset_hcount: got %0d want 0", bus.hcount); end
    n_cmp++; if (bus.vcount !== 10'd0) begin n_fail++; $display("FAIL reset_vcount: got %0d want 0", bus.vcount); end
    n_cmp++; if (bus.pix_en !== 1'b0) begin n_fail++; $display("FAIL reset_pix_en: got %b want 0", bus.pix_en); end
    n_cmp++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL reset_rgb: got %h want 00", rgb); end
    n_cmp++; if ({bus.hs, bus.vs} !== 2'b00) begin n_fail++; $display("FAIL reset_sync: got %b want 00", {bus.hs, bus.vs}); end
    n_cmp++; if (bus.spr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_spr_addr: got %h want 0", bus.spr_addr); end
    n_cmp++; if (bus.coll_frame !== 2'b00) begin n_fail++; $display("FAIL reset_coll: got %b want 00", bus.coll_frame); end
  endtask

  task automatic test_first_tick();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (bus.pix_en !== 1'b0) begin n_fail++; $display("FAIL tick_clk2: got %b want 0", bus.pix_en); end
    @(posedge clk); #1;
    n_cmp++; if (bus.pix_en !== 1'b1 || bus.hcount !== 10'd0) begin n_fail++; $display("FAIL tick_clk3: got pix_en=%b h=%0d want 1,0", bus.pix_en, bus.hcount); end
    @(posedge clk); #1;
    n_cmp++; if (bus.pix_en !== 1'b0 || bus.hcount !== 10'd1) begin n_fail++; $display("FAIL tick_clk4: got pix_en=%b h=%0d want 0,1", bus.pix_en, bus.hcount); end
  endtask

  task automatic test_counters();
    wait_pix(47, 3);
    @(posedge clk); #1;
    n_cmp++; if (bus.hcount !== 10'd0 || bus.vcount !== 10'd4) begin n_fail++; $display("FAIL line_wrap: got %0d,%0d want 0,4", bus.hcount, bus.vcount); end
    wait_pix(47, 11);
    @(posedge clk); #1;
    n_cmp++; if (bus.hcount !== 10'd0 || bus.vcount !== 10'd0) begin n_fail++; $display("FAIL frame_wrap: got %0d,%0d want 0,0", bus.hcount, bus.vcount); end
  endtask

  task automatic test_sync();
    wait_pix(1, 0);
    n_cmp++; if ({bus.hs, bus.vs} !== 2'b11) begin n_fail++; $display("FAIL sync_1_0: got %b want 11", {bus.hs, bus.vs}); end
    wait_pix(2, 0);
    n_cmp++; if ({bus.hs, bus.vs} !== 2'b00) begin n_fail++; $display("FAIL sync_2_0: got %b want 00", {bus.hs, bus.vs}); end
    wait_pix(5, 3);
    n_cmp++; if ({bus.hs, bus.vs} !== 2'b01) begin n_fail++; $display("FAIL sync_5_3: got %b want 01", {bus.hs, bus.vs}); end
    wait_pix(6, 3);
    n_cmp++; if ({bus.hs, bus.vs} !== 2'b11) begin n_fail++; $display("FAIL sync_6_3: got %b want 11", {bus.hs, bus.vs}); end
  endtask

  task automatic test_addr();
    bus.spr_pos = {PARK, 10'd20, 10'd5};
    bus.spr_off = {18'd0, 9'd16, 9'd0};
    wait_pix(0, 0);
    wait_pix(23, 7);
    @(posedge clk); #1;
    n_cmp++; if (bus.spr_addr[15:0] !== 16'd115) begin n_fail++; $display("FAIL spr_addr: got %0d want 115", bus.spr_addr[15:0]); end
    wait_pix(25, 7);
    n_cmp++; if (rgb !== 8'h73) begin n_fail++; $display("FAIL rom_pixel: got %h want 73", rgb); end
  endtask

  task automatic test_key();
    force_val[0] = 8'hFF;
    force_en[0]  = 1'b1;
    wait_pix(27, 8);
    n_cmp++; if (rgb !== 8'h1C) begin n_fail++; $display("FAIL key_transparent: got %h want 1c", rgb); end
    force_val[0] = 8'hE0;
    wait_pix(27, 9);
    n_cmp++; if (rgb !== 8'hE0) begin n_fail++; $display("FAIL key_opaque: got %h want e0", rgb); end
  endtask

  task automatic test_mid_frame();
    wait_pix(10, 10);
    bus.spr_pos = {PARK, 10'd30, 10'd5};
    wait_pix(24, 10);
    n_cmp++; if (rgb !== 8'hE0) begin n_fail++; $display("FAIL shadow_old_pos: got %h want e0", rgb); end
    wait_pix(24, 10);
    n_cmp++; if (rgb !== 8'h1C) begin n_fail++; $display("FAIL shadow_new_miss: got %h want 1c", rgb); end
    wait_pix(34, 10);
    n_cmp++; if (rgb !== 8'hE0) begin n_fail++; $display("FAIL shadow_new_hit: got %h want e0", rgb); end
  endtask

  task automatic test_wrap();
    bus.spr_pos = {PARK, 10'd1020, 10'd4};
    wait_pix(0, 0);
    wait_pix(10, 1);
    n_cmp++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL blank_vert: got %h want 00", rgb); end
    wait_pix(4, 5);
    n_cmp++; if (rgb !== 8'h1C) begin n_fail++; $display("FAIL wrap_no_hit: got %h want 1c", rgb); end
    wait_pix(44, 5);
    n_cmp++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL blank_horiz: got %h want 00", rgb); end
  endtask

  task automatic test_collide();
    logic [1:0] exp_coll;
`ifdef VGA_SPR_COLLIDE_EN
    exp_coll = 2'b11;
`else
    exp_coll = 2'b00;
`endif
    bus.spr_pos  = {10'd30, 10'd6, 10'd30, 10'd6};
    force_val[0] = 8'h03;
    force_val[1] = 8'hE0;
    force_en     = 2'b11;
    wait_pix(0, 0);
    wait_pix(33, 7);
    n_cmp++; if (rgb !== 8'h03) begin n_fail++; $display("FAIL priority: got %h want 03", rgb); end
    n_cmp++; if (bus.coll_frame !== 2'b00) begin n_fail++; $display("FAIL coll_prev: got %b want 00", bus.coll_frame); end
    wait_pix(2, 0);
    n_cmp++; if (bus.coll_frame !== exp_coll) begin n_fail++; $display("FAIL coll_frame: got %b want %b", bus.coll_frame, exp_coll); end
  endtask

  task automatic test_reset_mid();
    wait_pix(20, 6);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.hcount !== 10'd0 || bus.vcount !== 10'd0) begin n_fail++; $display("FAIL midrst_counters: got %0d,%0d want 0,0", bus.hcount, bus.vcount); end
    n_cmp++; if (rgb !== 8'h00 || bus.coll_frame !== 2'b00) begin n_fail++; $display("FAIL midrst_state: got rgb=%h coll=%b want 00,00", rgb, bus.coll_frame); end
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    force_en     = 2'b00;
    force_val[0] = 8'h00;
    force_val[1] = 8'h00;
    bus.spr_pos  = {PARK, PARK};
    bus.spr_off  = '0;
    bus.bg_rgb   = 8'h1C;
    test_reset();
    test_first_tick();
    test_counters();
    test_sync();
    test_addr();
    test_key();
    test_mid_frame();
    test_wrap();
    test_collide();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
